// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage with PC register, stall/redirect control and IF/ID register
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] inc_pc,
  output logic        if_valid
);
  typedef enum logic [1:0] {BOOT, FETCH, REDIR} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_inc;
  logic hs;
  assign imem_addr = pc;
  assign imem_req  = state == FETCH && !stall && !pc_src;
  assign hs        = imem_req && imem_ready;
  assign pc_inc    = pc + 32'd4;
  always_comb state_n = pc_src ? REDIR : stall ? state : FETCH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC & 32'hFFFF_FFFC;
      instr    <= '0;
      pc_out   <= '0;
      inc_pc   <= '0;
      if_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (pc_src) begin
        pc       <= target & 32'hFFFF_FFFC;
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_valid <= hs;
        if (hs) begin
          instr  <= imem_rdata;
          pc_out <= pc;
          inc_pc <= pc_inc;
          pc     <= pc_inc;
        end
      end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch
module tb_pc_fetch;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, pc_src = 1'b0, imem_ready = 1'b1;
  logic [31:0] target = '0;
  logic imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, inc_pc;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc_out, w_inc_pc;
  int n_tests = 0, n_fail = 0;
  localparam logic [31:0] K = 32'hA5A5_A5A5;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ K;
  assign w_rdata    = w_addr ^ K;
  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src), .target(target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .pc_out(pc_out), .inc_pc(inc_pc), .if_valid(if_valid)
  );
  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .pc_src(1'b0), .target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(w_rdata),
    .instr(w_instr), .pc_out(w_pc_out), .inc_pc(w_inc_pc), .if_valid(w_valid)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    tick();
    chk("boot_req", {31'b0, imem_req}, 32'h1);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_valid", {31'b0, if_valid}, 32'h0);
    chk("w_first", w_addr, 32'hFFFF_FFFC);
    tick();
    chk("f0_addr", imem_addr, 32'h4);
    chk("f0_instr", instr, 32'hA5A5_A5A5);
    chk("f0_pc", pc_out, 32'h0);
    chk("f0_inc", inc_pc, 32'h4);
    chk("f0_valid", {31'b0, if_valid}, 32'h1);
    chk("w_second", w_addr, 32'h0);
    chk("w_inc", w_inc_pc, 32'h0);
    chk("w_pc", w_pc_out, 32'hFFFF_FFFC);
    tick();
    chk("f1_addr", imem_addr, 32'h8);
    chk("f1_instr", instr, 32'hA5A5_A5A1);
    chk("f1_pc", pc_out, 32'h4);
    tick();
    tick();
    chk("f3_addr", imem_addr, 32'h10);
    chk("f3_pc", pc_out, 32'hC);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nr_addr", imem_addr, 32'h10);
      chk("nr_valid", {31'b0, if_valid}, 32'h0);
      chk("nr_pc", pc_out, 32'hC);
    end
    imem_ready = 1'b1;
    tick();
    chk("nr_instr", instr, 32'hA5A5_A5B5);
    chk("nr_pc10", pc_out, 32'h10);
    chk("nr_valid1", {31'b0, if_valid}, 32'h1);
    chk("nr_addr14", imem_addr, 32'h14);
    tick();
    chk("nr_once", pc_out, 32'h14);
    tick();
    tick();
    tick();
    chk("s_pc20", pc_out, 32'h20);
    chk("s_addr", imem_addr, 32'h24);
    stall = 1'b1;
    #1;
    chk("s_req0", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s_hold_pc", pc_out, 32'h20);
      chk("s_hold_instr", instr, 32'hA5A5_A585);
      chk("s_hold_valid", {31'b0, if_valid}, 32'h1);
      chk("s_hold_addr", imem_addr, 32'h24);
      chk("s_hold_req", {31'b0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    #1;
    chk("s_req1", {31'b0, imem_req}, 32'h1);
    tick();
    chk("s_resume_pc", pc_out, 32'h24);
    chk("s_resume_instr", instr, 32'hA5A5_A581);
    pc_src = 1'b1;
    target = 32'h0000_0103;
    stall = 1'b1;
    #1;
    chk("r_req0", {31'b0, imem_req}, 32'h0);
    tick();
    pc_src = 1'b0;
    stall = 1'b0;
    #1;
    chk("r_addr", imem_addr, 32'h100);
    chk("r_valid", {31'b0, if_valid}, 32'h0);
    chk("r_redir_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("r_fetch_req", {31'b0, imem_req}, 32'h1);
    chk("r_fetch_addr", imem_addr, 32'h100);
    chk("r_fetch_valid", {31'b0, if_valid}, 32'h0);
    tick();
    chk("r_pc", pc_out, 32'h100);
    chk("r_valid1", {31'b0, if_valid}, 32'h1);
    chk("r_addr104", imem_addr, 32'h104);
    pc_src = 1'b1;
    target = 32'h200;
    tick();
    target = 32'h304;
    tick();
    pc_src = 1'b0;
    #1;
    chk("rr_req0", {31'b0, imem_req}, 32'h0);
    chk("rr_addr", imem_addr, 32'h304);
    tick();
    chk("rr_req1", {31'b0, imem_req}, 32'h1);
    chk("rr_pc_hold", pc_out, 32'h100);
    pc_src = 1'b1;
    target = 32'h40;
    tick();
    pc_src = 1'b0;
    tick();
    chk("a_req", {31'b0, imem_req}, 32'h1);
    chk("a_addr", imem_addr, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_addr0", imem_addr, 32'h0);
    chk("a_instr0", instr, 32'h0);
    chk("a_pc0", pc_out, 32'h0);
    chk("a_inc0", inc_pc, 32'h0);
    chk("a_valid0", {31'b0, if_valid}, 32'h0);
    chk("a_req0", {31'b0, imem_req}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_boot_req", {31'b0, imem_req}, 32'h1);
    chk("a_boot_addr", imem_addr, 32'h0);
    chk("a_boot_valid", {31'b0, if_valid}, 32'h0);
    tick();
    chk("a_first_pc", pc_out, 32'h0);
    chk("a_first_valid", {31'b0, if_valid}, 32'h1);
    chk("a_first_addr", imem_addr, 32'h4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
